// File: rtl/updown_step_sequencer.sv
// Round-robin step sequencer for an external up/down counter. It accepts "step N up/down"
// commands from two requesters and stops early at the MIN/MAX bounds or on abort.
//
//  state | meaning
//  INIT  | counter clear pulse, one clock after reset release
//  IDLE  | arbitrate and accept one command
//  RUN   | one counter step per cycle until done, bound or abort
//  DONE  | one-cycle completion report
module updown_step_sequencer #(
    parameter int WIDTH     = 8,
    parameter int LEN_WIDTH = 8,
    parameter int MIN       = 0,
    parameter int MAX       = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic                 req0_up_i,
    input  logic [LEN_WIDTH-1:0] req0_len_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic                 req1_up_i,
    input  logic [LEN_WIDTH-1:0] req1_len_i,
    input  logic                 abort_i,
    input  logic [WIDTH-1:0]     count_i,
    output logic                 ctr_rst_o,
    output logic                 ctr_ce_o,
    output logic                 ctr_up_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 done_id_o,
    output logic                 done_trunc_o,
    output logic [LEN_WIDTH-1:0] steps_o
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX);

    logic [1:0]           r_state;
    logic                 r_rr;
    logic                 r_dir;
    logic                 r_id;
    logic                 r_trunc;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic [LEN_WIDTH-1:0] r_steps;

    logic w_grant0;
    logic w_grant1;
    logic w_ready0;
    logic w_ready1;
    logic w_at_limit;
    logic w_step;

    // r_rr = 0 gives requester 0 priority when both are valid
    assign w_grant0 = req0_valid_i && (!req1_valid_i || !r_rr);
    assign w_grant1 = req1_valid_i && (!req0_valid_i || r_rr);
    assign w_ready0 = (r_state == S_IDLE) && w_grant0;
    assign w_ready1 = (r_state == S_IDLE) && w_grant1;

    // count_i already reflects last cycle's step, so checking it here never overshoots
    assign w_at_limit = (r_dir && (count_i == L_MAX)) || (!r_dir && (count_i == L_MIN));
    assign w_step     = (r_state == S_RUN) && !abort_i && (r_remaining != '0) && !w_at_limit;

    assign req0_ready_o = w_ready0;
    assign req1_ready_o = w_ready1;
    assign ctr_ce_o     = w_step;
    assign ctr_up_o     = w_step && r_dir;
    assign ctr_rst_o    = (r_state == S_INIT);
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);
    assign done_id_o    = r_id;
    assign done_trunc_o = r_trunc;
    assign steps_o      = r_steps;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_INIT;
            r_rr        <= 1'b0;
            r_dir       <= 1'b0;
            r_id        <= 1'b0;
            r_trunc     <= 1'b0;
            r_remaining <= '0;
            r_steps     <= '0;
        end else begin
            case (r_state)
                S_INIT: r_state <= S_IDLE;
                S_IDLE: begin
                    if (w_ready0 || w_ready1) begin
                        r_dir       <= w_ready1 ? req1_up_i : req0_up_i;
                        r_remaining <= w_ready1 ? req1_len_i : req0_len_i;
                        r_id        <= w_ready1;
                        r_rr        <= w_ready0;
                        r_steps     <= '0;
                        r_trunc     <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        r_trunc <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_remaining == '0) begin
                        r_state <= S_DONE;
                    end else if (w_at_limit) begin
                        r_trunc <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        r_steps     <= r_steps + LEN_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_updown_step_sequencer.sv
// Bench for updown_step_sequencer with an attached behavioural up/down counter.
// Expected results come from bound arithmetic on the starting count, length and abort point.
module tb_updown_step_sequencer;

    localparam int W    = 8;
    localparam int LW   = 8;
    localparam int MINV = 0;
    localparam int MAXV = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v0, v1, up0, up1, abort;
    logic [LW-1:0] len0, len1;
    logic          ready0, ready1, ctr_rst, ctr_ce, ctr_up, busy, done, done_id, done_trunc;
    logic [LW-1:0] steps;
    logic [W-1:0]  ctr_count;

    int checks   = 0;
    int failures = 0;
    int last_served = 1;

    always #5 clk = ~clk;

    updown_step_sequencer #(.WIDTH(W), .LEN_WIDTH(LW), .MIN(MINV), .MAX(MAXV)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(v0), .req0_ready_o(ready0), .req0_up_i(up0), .req0_len_i(len0),
        .req1_valid_i(v1), .req1_ready_o(ready1), .req1_up_i(up1), .req1_len_i(len1),
        .abort_i(abort), .count_i(ctr_count),
        .ctr_rst_o(ctr_rst), .ctr_ce_o(ctr_ce), .ctr_up_o(ctr_up),
        .busy_o(busy), .done_o(done), .done_id_o(done_id), .done_trunc_o(done_trunc),
        .steps_o(steps)
    );

    always_ff @(posedge clk) begin
        if (ctr_rst)     ctr_count <= '0;
        else if (ctr_ce) ctr_count <= ctr_up ? ctr_count + 8'd1 : ctr_count - 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts in an IDLE cycle just after a rising edge; returns likewise.
    task automatic do_cmd(input int rq, input bit up, input int len, input int abort_at,
                          input string tag);
        int c0, nat, exp_steps, ce_cnt, done_cyc;
        bit exp_trunc, up_ok;
        c0  = int'(ctr_count);
        nat = up ? (MAXV - c0) : (c0 - MINV);
        if (nat > len) nat = len;
        if (abort_at >= 0 && abort_at <= nat) begin
            exp_steps = abort_at; exp_trunc = 1'b1;
        end else begin
            exp_steps = nat;      exp_trunc = (nat < len);
        end
        if (rq == 0) begin v0 = 1'b1; up0 = up; len0 = LW'(len); end
        else         begin v1 = 1'b1; up1 = up; len1 = LW'(len); end
        @(negedge clk);
        chk({tag, "_ready"}, 32'(rq == 0 ? ready0 : ready1), 32'd1);
        chk({tag, "_other_ready"}, 32'(rq == 0 ? ready1 : ready0), 32'd0);
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        ce_cnt = 0; done_cyc = -1; up_ok = 1'b1;
        for (int cyc = 1; cyc <= len + 4; cyc++) begin
            abort = (cyc == abort_at + 1);
            @(negedge clk);
            if (ctr_ce) begin
                ce_cnt++;
                if (ctr_up !== up) up_ok = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        chk({tag, "_done_latency"}, 32'(done_cyc), 32'(exp_steps + 2));
        chk({tag, "_steps"}, 32'(steps), 32'(exp_steps));
        chk({tag, "_trunc"}, 32'(done_trunc), 32'(exp_trunc));
        chk({tag, "_id"}, 32'(done_id), 32'(rq));
        chk({tag, "_ce_count"}, 32'(ce_cnt), 32'(exp_steps));
        chk({tag, "_ce_dir"}, 32'(up_ok), 32'd1);
        chk({tag, "_count"}, 32'(ctr_count), 32'(up ? c0 + exp_steps : c0 - exp_steps));
        last_served = rq;
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_g, done_cyc, rq, len, ab;
        bit up;
        rst_n = 1'b0; v0 = 1'b1; v1 = 1'b0; up0 = 1'b1; up1 = 1'b0;
        len0 = '0; len1 = '0; abort = 1'b0;

        // reset and INIT clear pulse
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(ready0), 32'd0);
        chk("rst_ce", 32'(ctr_ce), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ctr_rst", 32'(ctr_rst), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_ctr_rst", 32'(ctr_rst), 32'd1);
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_ready0", 32'(ready0), 32'd0);
        @(negedge clk);
        chk("idle_ctr_rst", 32'(ctr_rst), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_count", 32'(ctr_count), 32'd0);
        chk("idle_ready0", 32'(ready0), 32'd1);
        v0 = 1'b0;
        @(posedge clk); #1;

        // directed commands
        do_cmd(0, 1'b1, 5, -1, "up5");
        do_cmd(1, 1'b1, 3, -1, "up3");
        do_cmd(0, 1'b1, 5, -1, "max_trunc");
        do_cmd(1, 1'b0, 9, -1, "down9");
        do_cmd(0, 1'b0, 3, -1, "min_trunc");
        do_cmd(1, 1'b1, 0, -1, "len0");
        do_cmd(0, 1'b1, 8, 3, "abort3");

        // both requesters held valid: grants must alternate
        v0 = 1'b1; up0 = 1'b1; len0 = 8'd2;
        v1 = 1'b1; up1 = 1'b0; len1 = 8'd2;
        for (int r = 0; r < 4; r++) begin
            exp_g = 1 - last_served;
            @(negedge clk);
            chk("rr_ready0", 32'(ready0), 32'(exp_g == 0));
            chk("rr_ready1", 32'(ready1), 32'(exp_g == 1));
            done_cyc = -1;
            for (int cyc = 1; cyc <= 10; cyc++) begin
                @(negedge clk);
                chk("rr_not_both_ready", 32'(ready0 && ready1), 32'd0);
                if (done) begin
                    done_cyc = cyc;
                    break;
                end
            end
            chk("rr_done_latency", 32'(done_cyc), 32'd4);
            chk("rr_id", 32'(done_id), 32'(exp_g));
            chk("rr_steps", 32'(steps), 32'd2);
            last_served = exp_g;
        end
        v0 = 1'b0; v1 = 1'b0;
        @(posedge clk); #1;

        // randomized commands
        for (int i = 0; i < 40; i++) begin
            rq  = int'($urandom_range(0, 1));
            up  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(0, 12));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
            do_cmd(rq, up, len, ab, "rand");
        end

        // reset in the middle of a command
        up = (ctr_count < 8'd5);
        v0 = 1'b1; up0 = up; len0 = 8'd8;
        @(posedge clk); #1 v0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrun_ce_before", 32'(ctr_ce), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrun_ce_reset", 32'(ctr_ce), 32'd0);
        chk("midrun_busy_reset", 32'(busy), 32'd1);
        chk("midrun_ctr_rst", 32'(ctr_rst), 32'd1);
        v0 = 1'b1; up0 = 1'b1; len0 = 8'd1;
        repeat (2) begin
            @(negedge clk);
            chk("midrun_no_done", 32'(done), 32'd0);
            chk("midrun_no_ce", 32'(ctr_ce), 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reinit_ctr_rst", 32'(ctr_rst), 32'd1);
        chk("reinit_ready0", 32'(ready0), 32'd0);
        @(negedge clk);
        chk("reinit_ctr_rst_low", 32'(ctr_rst), 32'd0);
        chk("reinit_count", 32'(ctr_count), 32'd0);
        chk("reinit_ready0", 32'(ready0), 32'd1);
        chk("reinit_no_done", 32'(done), 32'd0);
        v0 = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
